// File: rtl/oh_delay_pkg.sv
// Shared definitions for the delay-line calibration controller:
// FSM state encoding and the tap code the line is parked at after reset or a failed sweep.
package oh_delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } dly_state_t;

    localparam int unsigned RST_CODE = 0;

endpackage

// File: rtl/oh_delay_settle.sv
// Settle counter: cleared by load, advances while enabled, flags the last settle cycle.
module oh_delay_settle #(
    parameter int unsigned SW     = 3,
    parameter int unsigned SETTLE = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    logic [SW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + SW'(1);
        end
    end

    assign o_tc = (r_cnt == SW'(SETTLE - 1));

endmodule

// File: rtl/oh_delay_ctrl.sv
// Delay-line calibration: sweeps the tap code upward, finds the first run of sample=1
// codes and parks the code at the floored centre of that run; manual code when idle.
module oh_delay_ctrl
    import oh_delay_pkg::*;
#(
    parameter int unsigned TW     = 5,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned SW     = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          sample,
    input  logic          cfg_manual,
    input  logic [TW-1:0] cfg_code,
    output logic [TW-1:0] code,
    output logic          busy,
    output logic          done,
    output logic          fail
);

    dly_state_t    r_state;
    dly_state_t    w_next;
    logic [TW-1:0] r_code;
    logic [TW-1:0] r_lo;
    logic [TW-1:0] r_hi;
    logic          r_found;
    logic          r_busy;
    logic          r_done;
    logic          r_fail;
    logic          w_tc;
    logic          w_last;
    logic          w_run_end;
    logic [TW-1:0] w_mid;

    oh_delay_settle #(
        .SW     (SW),
        .SETTLE (SETTLE)
    ) u_settle (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_load (r_state != ST_SETTLE),
        .i_en   (r_state == ST_SETTLE),
        .o_tc   (w_tc)
    );

    assign w_last    = (r_code == '1);
    assign w_run_end = r_found && !sample;
    // Sum at TW+1 bits so lo+hi cannot overflow before the halving.
    assign w_mid     = TW'(({1'b0, r_lo} + {1'b0, r_hi}) >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_SETTLE;
            ST_SETTLE: if (w_tc) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = (w_run_end || w_last) ? ST_DONE : ST_SETTLE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code  <= TW'(RST_CODE);
            r_lo    <= '0;
            r_hi    <= '0;
            r_found <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_code  <= TW'(RST_CODE);
                        r_found <= 1'b0;
                        r_fail  <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (cfg_manual) begin
                        r_code <= cfg_code;
                    end
                end
                ST_SAMPLE: begin
                    // Once a run has closed, later sample=1 codes are never reached.
                    if (sample) begin
                        if (!r_found) begin
                            r_lo    <= r_code;
                            r_found <= 1'b1;
                        end
                        r_hi <= r_code;
                    end
                    if (!w_run_end && !w_last) begin
                        r_code <= r_code + TW'(1);
                    end
                end
                ST_DONE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (r_found) begin
                        r_code <= w_mid;
                    end else begin
                        r_fail <= 1'b1;
                        r_code <= TW'(RST_CODE);
                    end
                end
                default: ;
            endcase
        end
    end

    assign code = r_code;
    assign busy = r_busy;
    assign done = r_done;
    assign fail = r_fail;

endmodule

// File: tb/tb_oh_delay_ctrl.sv
// Randomized bench for oh_delay_ctrl: phase detector modelled as a per-code mask,
// expected park code / fail / latency derived from the mask by a first-run search.
module tb_oh_delay_ctrl;

    localparam int unsigned TW     = 4;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned SW     = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          sample;
    logic          cfg_manual;
    logic [TW-1:0] cfg_code;
    logic [TW-1:0] code;
    logic          busy;
    logic          done;
    logic          fail;
    logic [15:0]   mask;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    always_comb sample = mask[code];

    oh_delay_ctrl #(
        .TW     (TW),
        .SETTLE (SETTLE),
        .SW     (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sample     (sample),
        .cfg_manual (cfg_manual),
        .cfg_code   (cfg_code),
        .code       (code),
        .busy       (busy),
        .done       (done),
        .fail       (fail)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // First contiguous run of ones in the mask, scanning codes upward.
    task automatic ref_cal(input logic [15:0] m, output int unsigned ecode,
                           output logic efail, output int unsigned elat);
        int unsigned lo, hi, endc;
        bit found, closed;
        found = 0; closed = 0; lo = 0; hi = 0; endc = 15;
        for (int c = 0; c < 16; c++) begin
            if (!closed) begin
                if (m[c]) begin
                    if (!found) lo = c;
                    found = 1;
                    hi = c;
                end else if (found) begin
                    closed = 1;
                    endc = c;
                end
            end
        end
        ecode = found ? (lo + hi) / 2 : 0;
        efail = !found;
        elat  = (endc + 1) * (SETTLE + 1) + 2;
    endtask

    task automatic run_cal(input string tag, input logic [15:0] m, input bit noise);
        int unsigned ecode, elat, n;
        logic efail;
        logic [TW-1:0] held;
        ref_cal(m, ecode, efail, elat);
        mask  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "/busy_on"}, busy, 1);
        check({tag, "/code_start"}, code, 0);
        check({tag, "/fail_clr"}, fail, 0);
        n = 1;
        while (!done && n < 400) begin
            if (noise) begin
                start      = ($urandom_range(0, 3) == 0);
                cfg_manual = $urandom_range(0, 1);
                cfg_code   = TW'($urandom);
            end
            tick();
            n++;
        end
        start      = 1'b0;
        cfg_manual = 1'b0;
        check({tag, "/latency"}, n, elat);
        check({tag, "/code"}, code, ecode);
        check({tag, "/fail"}, fail, efail);
        check({tag, "/busy_off"}, busy, 0);
        held = code;
        tick();
        check({tag, "/done_pulse"}, done, 0);
        check({tag, "/code_hold"}, code, held);
    endtask

    initial begin
        int unsigned n, pulses, lo, hi;
        logic [15:0] m;
        reset      = 1'b1;
        start      = 1'b0;
        cfg_manual = 1'b0;
        cfg_code   = '0;
        mask       = '0;
        repeat (3) tick();
        check("rst/code", code, 0);
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/fail", fail, 0);
        reset = 1'b0;
        tick();
        check("idle/code", code, 0);
        check("idle/busy", busy, 0);

        run_cal("win5_9", 16'h03E0, 1'b0);
        run_cal("win12_15", 16'hF000, 1'b1);
        run_cal("nohit", 16'h0000, 1'b0);
        run_cal("refail", 16'h0040, 1'b0);
        run_cal("single3", 16'h0708, 1'b1);

        // Reset part-way through a sweep.
        mask  = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (code != 6 && n < 200) begin
            tick();
            n++;
        end
        check("mid/reach6", code, 6);
        reset = 1'b1;
        tick();
        check("mid/code", code, 0);
        check("mid/busy", busy, 0);
        check("mid/done", done, 0);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done) pulses++;
        end
        check("mid/no_done", pulses, 0);
        check("mid/still_idle", busy, 0);

        // Manual override while idle.
        cfg_manual = 1'b1;
        cfg_code   = 4'd9;
        tick();
        check("man/code9", code, 9);
        cfg_code = 4'd2;
        tick();
        check("man/code2", code, 2);
        cfg_manual = 1'b0;
        cfg_code   = 4'd5;
        tick();
        check("man/hold", code, 2);
        cfg_manual = 1'b1;
        cfg_code   = 4'd11;
        run_cal("man_start", 16'h0180, 1'b1);

        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 2))
                0: m = 16'($urandom & $urandom);
                1: begin
                    lo = $urandom_range(0, 15);
                    hi = $urandom_range(lo, 15);
                    m  = '0;
                    for (int c = 0; c < 16; c++) begin
                        if (c >= lo && c <= hi) m[c] = 1'b1;
                        else if (c > hi + 1) m[c] = 1'($urandom);
                    end
                end
                default: m = 16'($urandom);
            endcase
            run_cal($sformatf("rnd%0d", k), m, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
